// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on a word array behind a
// valid/ready request channel and a valid/ready response channel. XLEN must be 32.
// Optional macro DMEM_PIPE_EN lets a new request be accepted during the response handshake.
module dmem_responder #(
  parameter int XLEN      = 32,
  parameter int DMEM_SIZE = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int AW = $clog2(DMEM_SIZE);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DMEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rd_word_q;
  logic [XLEN-1:0]   mem [DMEM_SIZE];

  logic              capture;
  logic              access_err;
  logic              mem_we;
  logic [AW-1:0]     word_idx;
  logic [3:0]        byte_en;
  logic [XLEN-1:0]   wdata_lanes;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [XLEN-1:0]   load_data;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
`ifdef DMEM_PIPE_EN
        req_ready_o = rsp_ready_i;
`else
        req_ready_o = 1'b0;
`endif
        if (rsp_ready_i) state_d = (req_valid_i && req_ready_o) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign capture    = req_valid_i && req_ready_o;
  assign word_idx   = addr_q[AW+1:2];
  assign access_err = (size_q == 2'b11)
                   || (size_q == 2'b01 && addr_q[0])
                   || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                   || (addr_q >= ADDR_LIMIT);
  assign mem_we     = (state_q == ACCESS) && we_q && !access_err;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = '0;
    case (size_q)
      2'b00: begin
        byte_en     = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata_q;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
    if (state_q == ACCESS && !we_q) rd_word_q <= mem[word_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
      end
      if (state_q == ACCESS) err_q <= access_err;
    end
  end

  assign sel_byte = rd_word_q[8*addr_q[1:0] +: 8];
  assign sel_half = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

  always_comb begin
    load_data = rd_word_q;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_data = rd_word_q;
    endcase
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model, per-cycle response
// monitor, and directed vectors pinned with literal expectations.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          known;
    int          acc_cyc;
  } exp_t;

`ifdef DMEM_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          last_pop_cyc = 0;
  int          first_acc;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  bit          head_seen = 1'b0;
  logic [7:0]  ref_mem [4096];
  bit          ref_known [4096];
  exp_t        exp_q [$];

  dmem_responder #(.XLEN(32), .DMEM_SIZE(1024)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Little-endian byte-array model of the memory, applied at the moment a request is accepted.
  function automatic exp_t model_access(input logic [31:0] addr, input logic we,
                                        input logic [1:0] size, input logic uns,
                                        input logic [31:0] wdata);
    exp_t        e;
    int          base, n;
    logic [31:0] v;
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0])
         || (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd4096);
    e.rdata   = '0;
    e.known   = 1'b1;
    e.acc_cyc = 0;
    if (!e.err) begin
      base = int'(addr);
      n    = 1 << int'(size);
      v    = '0;
      for (int i = 0; i < n; i++) begin
        if (we) begin
          ref_mem[base+i]   = wdata[8*i +: 8];
          ref_known[base+i] = 1'b1;
        end else begin
          v[8*i +: 8] = ref_mem[base+i];
          if (!ref_known[base+i]) e.known = 1'b0;
        end
      end
      if (!we) begin
        if (!uns && size == 2'b00) v[31:8]  = {24{v[7]}};
        if (!uns && size == 2'b01) v[31:16] = {16{v[15]}};
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Every cycle a response is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        if (!head_seen) begin
          checkOutput("latency", cyc - exp_q[0].acc_cyc, 32'd2);
          head_seen = 1'b1;
        end
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        if (exp_q[0].known) checkOutput("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        checkOutput("req_ready_in_resp", {31'd0, req_ready}, {31'd0, PIPE & rsp_ready});
        if (rsp_ready) begin
          last_rdata   = rsp_rdata;
          last_err     = rsp_err;
          last_pop_cyc = cyc;
          void'(exp_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input bit track = 1'b1);
    exp_t e;
    bit   done = 1'b0;
    req_addr     = addr;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done         = 1'b1;
        last_acc_cyc = cyc;
        if (track) begin
          e         = model_access(addr, we, size, uns, wdata);
          e.acc_cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
    if (!done) checkOutput("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checkOutput("rsp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    #12;
    checkResetOutputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF); waitIdle();
    checkOutput("sw_rdata", last_rdata, 32'h0);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_0x10", last_rdata, 32'hDEADBEEF);

    applyStimulus(32'h11, 1'b1, 2'b00, 1'b0, 32'h80); waitIdle();
    applyStimulus(32'h11, 1'b0, 2'b00, 1'b0, 32'h0); waitIdle();
    checkOutput("lb_0x11", last_rdata, 32'hFFFFFF80);
    applyStimulus(32'h11, 1'b0, 2'b00, 1'b1, 32'h0); waitIdle();
    checkOutput("lbu_0x11", last_rdata, 32'h00000080);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_after_sb", last_rdata, 32'hDEAD80EF);

    applyStimulus(32'h12, 1'b0, 2'b01, 1'b0, 32'h0); waitIdle();
    checkOutput("lh_0x12", last_rdata, 32'hFFFFDEAD);
    applyStimulus(32'h12, 1'b0, 2'b01, 1'b1, 32'h0); waitIdle();
    checkOutput("lhu_0x12", last_rdata, 32'h0000DEAD);

    applyStimulus(32'h13, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_misaligned_err", {31'd0, last_err}, 32'd1);
    checkOutput("lw_misaligned_rdata", last_rdata, 32'h0);
    applyStimulus(32'h11, 1'b1, 2'b01, 1'b0, 32'h0000FFFF); waitIdle();
    checkOutput("sh_misaligned_err", {31'd0, last_err}, 32'd1);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_after_bad_sh", last_rdata, 32'hDEAD80EF);
    applyStimulus(32'h1000, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_out_of_range_err", {31'd0, last_err}, 32'd1);
    applyStimulus(32'h10, 1'b0, 2'b11, 1'b0, 32'h0); waitIdle();
    checkOutput("size_invalid_err", {31'd0, last_err}, 32'd1);

    // Backpressure: hold the response with a second request waiting.
    rsp_ready = 1'b0;
    applyStimulus(32'h12, 1'b0, 2'b01, 1'b1, 32'h0);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req_addr = 32'h10; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'h0000DEAD);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    waitIdle();
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_after_bp", last_rdata, 32'hDEAD80EF);

    // Reset lands while a store sits between capture and its write edge.
    applyStimulus(32'h20, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D); waitIdle();
    applyStimulus(32'h20, 1'b1, 2'b10, 1'b0, 32'h12345678, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h20, 1'b0, 2'b10, 1'b0, 32'h0); waitIdle();
    checkOutput("lw_after_dropped_sw", last_rdata, 32'hCAFEF00D);

    // Back-to-back loads with the response side always ready.
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
    first_acc = last_acc_cyc;
    applyStimulus(32'h20, 1'b0, 2'b10, 1'b0, 32'h0);
    applyStimulus(32'h12, 1'b0, 2'b01, 1'b0, 32'h0);
    applyStimulus(32'h11, 1'b0, 2'b00, 1'b1, 32'h0);
    waitIdle();
    checkOutput("throughput_cycles", last_pop_cyc - first_acc, PIPE ? 32'd8 : 32'd11);
    checkOutput("last_b2b_rdata", last_rdata, 32'h00000080);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
